// File: rtl/regfile_write_port_pkg.sv
// Shared constants and types for the register-file write port.
// Forward-select encodings and the register address width live here.
package regfile_write_port_pkg;

   localparam int unsigned REG_AW = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam reg_addr_t  REG_ZERO = '0;

endpackage

// File: rtl/regfile_write_port_wb_fifo.sv
// In-order write-back buffer: circular storage with head/tail/count and
// per-entry valid/rd/data exposed so the top can search pending writes.
module regfile_write_port_wb_fifo
   import regfile_write_port_pkg::*;
#(
   parameter int unsigned d_size    = 32,
   parameter int unsigned buf_depth = 2,
   localparam int unsigned PtrW     = $clog2(buf_depth)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  reg_addr_t         push_rd,
   input  logic [d_size-1:0] push_data,
   output logic              full,
   output logic              empty,
   output logic [PtrW-1:0]   head_ptr,
   output reg_addr_t         head_rd,
   output logic [d_size-1:0] head_data,
   output logic              ent_valid [buf_depth],
   output reg_addr_t         ent_rd    [buf_depth],
   output logic [d_size-1:0] ent_data  [buf_depth]
);

   logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [PtrW:0]     count_q, count_d;
   logic              valid_q [buf_depth];
   logic              valid_d [buf_depth];
   reg_addr_t         rd_q    [buf_depth];
   reg_addr_t         rd_d    [buf_depth];
   logic [d_size-1:0] data_q  [buf_depth];
   logic [d_size-1:0] data_d  [buf_depth];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      rd_d    = rd_q;
      data_d  = data_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         for (int unsigned i = 0; i < buf_depth; i++) valid_d[i] = 1'b0;
      end else begin
         if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PtrW'(1);
         end
         // Push after pop so a full-buffer push into the slot being freed wins.
         if (push) begin
            valid_d[tail_q] = 1'b1;
            rd_d[tail_q]    = push_rd;
            data_d[tail_q]  = push_data;
            tail_d          = tail_q + PtrW'(1);
         end
         count_d = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < buf_depth; i++) begin
            valid_q[i] <= 1'b0;
            rd_q[i]    <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

   assign full      = (count_q == (PtrW+1)'(buf_depth));
   assign empty     = (count_q == '0);
   assign head_ptr  = head_q;
   assign head_rd   = rd_q[head_q];
   assign head_data = data_q[head_q];
   assign ent_valid = valid_q;
   assign ent_rd    = rd_q;
   assign ent_data  = data_q;

endmodule

// File: rtl/regfile_write_port.sv
// Register-file write side: buffers write-backs, commits one per cycle into
// the array, and forwards the youngest pending write to the EX read ports.
module regfile_write_port
   import regfile_write_port_pkg::*;
#(
   parameter int unsigned d_size    = 32,
   parameter int unsigned depth     = 32,
   parameter int unsigned buf_depth = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd,
   input  logic [d_size-1:0] wb_data,
   output logic              wb_ready,
   input  logic              wr_hold,
   input  logic              flush,
   input  logic [4:0]        rf_rs,
   input  logic [4:0]        rf_rt,
   output logic [1:0]        ForwardA,
   output logic [1:0]        ForwardB,
   output logic [d_size-1:0] fwd_data_a,
   output logic [d_size-1:0] fwd_data_b,
   output logic [d_size-1:0] rf_rdata1,
   output logic [d_size-1:0] rf_rdata2,
   output logic              commit_valid,
   output logic [4:0]        commit_rd,
   output logic [d_size-1:0] commit_data,
   output logic              busy
);

   localparam int unsigned PtrW = $clog2(buf_depth);
   localparam int unsigned RfAW = $clog2(depth);

   logic              push, pop, full, empty;
   logic [PtrW-1:0]   head_ptr;
   reg_addr_t         head_rd;
   logic [d_size-1:0] head_data;
   logic              ent_valid [buf_depth];
   reg_addr_t         ent_rd    [buf_depth];
   logic [d_size-1:0] ent_data  [buf_depth];

   logic [d_size-1:0] rf_q [depth];
   logic [d_size-1:0] rf_d [depth];
   logic              commit_valid_q, commit_valid_d;
   reg_addr_t         commit_rd_q, commit_rd_d;
   logic [d_size-1:0] commit_data_q, commit_data_d;

   // Flush blocks both the handshake and the commit of the head entry.
   assign pop      = !empty && !wr_hold && !flush;
   assign wb_ready = !flush && (!full || pop);
   assign push     = wb_valid && wb_ready && (wb_rd != REG_ZERO);

   regfile_write_port_wb_fifo #(
      .d_size    (d_size),
      .buf_depth (buf_depth)
   ) u_wb_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_rd   (wb_rd),
      .push_data (wb_data),
      .full      (full),
      .empty     (empty),
      .head_ptr  (head_ptr),
      .head_rd   (head_rd),
      .head_data (head_data),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd),
      .ent_data  (ent_data)
   );

   always_comb begin
      rf_d           = rf_q;
      commit_valid_d = pop;
      commit_rd_d    = commit_rd_q;
      commit_data_d  = commit_data_q;
      if (pop) begin
         if (head_rd != REG_ZERO) rf_d[head_rd[RfAW-1:0]] = head_data;
         commit_rd_d   = head_rd;
         commit_data_d = head_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < depth; i++) rf_q[i] <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_data_q  <= '0;
      end else begin
         rf_q           <= rf_d;
         commit_valid_q <= commit_valid_d;
         commit_rd_q    <= commit_rd_d;
         commit_data_q  <= commit_data_d;
      end
   end

   // Walk oldest to youngest from head so the last match is the youngest.
   always_comb begin
      logic [PtrW-1:0] idx;
      idx        = '0;
      ForwardA   = FWD_NONE;
      ForwardB   = FWD_NONE;
      fwd_data_a = '0;
      fwd_data_b = '0;
      for (int unsigned i = 0; i < buf_depth; i++) begin
         idx = head_ptr + PtrW'(i);
         if (ent_valid[idx] && (ent_rd[idx] == rf_rs) && (rf_rs != REG_ZERO)) begin
            ForwardA   = FWD_WB;
            fwd_data_a = ent_data[idx];
         end
         if (ent_valid[idx] && (ent_rd[idx] == rf_rt) && (rf_rt != REG_ZERO)) begin
            ForwardB   = FWD_WB;
            fwd_data_b = ent_data[idx];
         end
      end
   end

   assign rf_rdata1    = (rf_rs == REG_ZERO) ? '0 : rf_q[rf_rs[RfAW-1:0]];
   assign rf_rdata2    = (rf_rt == REG_ZERO) ? '0 : rf_q[rf_rt[RfAW-1:0]];
   assign commit_valid = commit_valid_q;
   assign commit_rd    = commit_rd_q;
   assign commit_data  = commit_data_q;
   assign busy         = !empty;

endmodule

// File: doc/regfile_write_port.md
# regfile_write_port

Write side of the processor's register file. It accepts write-back results from the MEM stage through a valid/ready handshake and queues them in a small in-order buffer. It commits one entry per cycle into the architectural register array and generates the ForwardA/ForwardB selects and forwarded operands for the EX-stage operand read path, so that pending writes are never missed.

## Interface
Parameters:
- d_size, 32, data width
- depth, 32, number of architectural registers (register 0 hard-wired to zero)
- buf_depth, 2, write-buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_valid  in  1  write-back request present
- wb_rd  in  5  destination register address
- wb_data  in  d_size  write data
- wb_ready  out  1  buffer can accept this cycle
- wr_hold  in  1  inhibit commit this cycle (debug/test port access)
- flush  in  1  discard all uncommitted entries
- rf_rs, rf_rt  in  5  EX-stage source addresses
- ForwardA, ForwardB  out  2  forward select: 2'b01 means pending write forwarded, 2'b00 means use array
- fwd_data_a, fwd_data_b  out  d_size  youngest pending data for rs/rt (0 when no match)
- rf_rdata1, rf_rdata2  out  d_size  architectural array contents at rs/rt
- commit_valid  out  1  entry committed on the last edge
- commit_rd  out  5  address of the last committed entry
- commit_data  out  d_size  data of the last committed entry
- busy  out  1  buffer non-empty

## Operation
- Accept: wb_valid & wb_ready at an edge completes the handshake. If wb_rd == 0, the request is accepted and dropped (not enqueued). Otherwise it is enqueued at the tail.
- wb_ready = !full | (commit this cycle). A same-cycle commit frees a slot.
- Commit: when the buffer is non-empty and wr_hold = 0, the head entry is written to the array and popped at the edge. commit_valid/rd/data register that entry for one cycle. Otherwise commit_valid = 0 and rd/data hold their values.
- Forwarding (combinational): for each of rs and rt, search valid buffer entries. The youngest entry with a matching rd wins, giving ForwardX = 2'b01 and fwd_data_x = its data. An address of 0 never matches. A request not yet accepted is never forwarded.
- Read ports rf_rdata1/2 are combinational array reads. Address 0 returns 0.
- Flush: at the edge, all entries are invalidated and the count goes to 0. A same-cycle accept is discarded and a same-cycle commit is suppressed. wb_ready is forced to 0 during flush.
- Simultaneous accept and commit: count is unchanged and both take effect.
- Reset: array cleared to 0, head/tail/count = 0, commit_valid = 0, commit_rd = 0, commit_data = 0. Hence busy = 0, wb_ready = 1, ForwardA/B = 2'b00. Reset mid-operation discards pending writes.

## Timing
- Accept-to-commit latency: 1 cycle with an empty buffer and no hold. The entry accepted at edge N is written at edge N+1, visible on rf_rdata from N+1, and commit_valid is high in cycle N+1..N+2.
- Forward visibility: from the cycle after acceptance until the cycle its commit edge occurs. After commit, the array path supplies the value.
- Pointers wrap modulo buf_depth. Count ranges 0..buf_depth.
- Throughput: 1 write/cycle sustained without wr_hold. With wr_hold high, the buffer fills after buf_depth accepts, then wb_ready = 0.

## Structure
- Shared package: FWD_NONE = 2'b00, FWD_WB = 2'b01, REG_ZERO = 5'd0, register address width constant.
- Sub-module wb_fifo: storage, pointers, count, push/pop/flush, and per-entry valid/rd/data exposed for the match logic.
- Top level: array, commit register, youngest-match priority search for the two read ports.

## Test plan
- Single write: accept rd=5, data=0x41 into an idle block. Forward is 2'b01 with fwd_data_a = 0x41 for rs=5 in the next cycle. Commit occurs the following edge, after which rf_rdata1 = 0x41, ForwardA = 2'b00, and commit_valid pulses once.
- Youngest wins: with wr_hold=1, accept rd=3 data=7 then rd=3 data=9. rs=rt=3 gives ForwardA = ForwardB = 2'b01 with data 9. After release, the array ends at 9.
- Full/backpressure: with buf_depth=2 and wr_hold=1, two accepts make wb_ready = 0. Dropping wr_hold gives wb_ready = 1 in the same cycle, and an accept plus a commit leave the count at 2.
- Register zero: a write of rd=0 data=0xFF completes the handshake, busy stays 0, and rf_rdata1 for rs=0 is 0 with no forward.
- Flush: with two pending entries, pulse flush together with wb_valid. The result is count 0, no commit, array unchanged, and the incoming request lost.
- Async reset: assert rst mid-cycle with pending entries. All outputs go to reset values immediately and the array reads 0.
